// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined right shifter: operation encodings and default sizing.
package shift_pkg;

  localparam logic [1:0] SHR_LOGICAL = 2'b00;
  localparam logic [1:0] SHR_ARITH   = 2'b01;
  localparam logic [1:0] SHR_ROTATE  = 2'b10;

  localparam int SHR_DEFAULT_OPERAND_WIDTH = 16;
  localparam int SHR_DEFAULT_SHAMT_WIDTH   = 4;
  localparam int SHR_NUM_STAGES            = SHR_DEFAULT_SHAMT_WIDTH;

endpackage

// File: rtl/shift_right_stage.sv
// One pipeline stage of the right shifter: conditionally shifts by 2^STAGE_IDX on entry
// and holds valid/data/control while the downstream stage is stalled.
module shift_right_stage
  import shift_pkg::*;
#(
  parameter int OPERAND_WIDTH = SHR_DEFAULT_OPERAND_WIDTH,
  parameter int SHAMT_WIDTH   = SHR_DEFAULT_SHAMT_WIDTH,
  parameter int STAGE_IDX     = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [OPERAND_WIDTH-1:0] in_data,
  input  logic [SHAMT_WIDTH-1:0]   in_shamt,
  input  logic [1:0]               in_oper,
  input  logic                     next_advance,
  output logic                     advance,
  output logic                     valid,
  output logic [OPERAND_WIDTH-1:0] data,
  output logic [SHAMT_WIDTH-1:0]   shamt,
  output logic [1:0]               oper
);

  localparam int SHIFT = 1 << STAGE_IDX;

  logic [OPERAND_WIDTH-1:0] shifted;

  // Arithmetic fill uses the current MSB, which always equals the original sign bit
  // because every earlier arithmetic stage replicated it.
  always_comb begin
    shifted = in_data;
    if (in_shamt[STAGE_IDX]) begin
      case (in_oper)
        SHR_ARITH:  shifted = {{SHIFT{in_data[OPERAND_WIDTH-1]}}, in_data[OPERAND_WIDTH-1:SHIFT]};
        SHR_ROTATE: shifted = {in_data[SHIFT-1:0], in_data[OPERAND_WIDTH-1:SHIFT]};
        default:    shifted = {{SHIFT{1'b0}}, in_data[OPERAND_WIDTH-1:SHIFT]};
      endcase
    end
  end

  assign advance = !valid || next_advance;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      shamt <= '0;
      oper  <= SHR_LOGICAL;
    end else if (advance) begin
      valid <= in_valid;
      if (in_valid) begin
        data  <= shifted;
        shamt <= in_shamt;
        oper  <= in_oper;
      end
    end
  end

endmodule

// File: rtl/shift_right_pipe.sv
// Pipelined right shifter/rotator, one stage per shift-amount bit, valid/ready on both ends.
// Optional single-cycle bypass path enabled by defining SHR_PIPE_BYPASS_EN.
module shift_right_pipe
  import shift_pkg::*;
#(
  parameter int OPERAND_WIDTH = SHR_DEFAULT_OPERAND_WIDTH,
  parameter int SHAMT_WIDTH   = SHR_DEFAULT_SHAMT_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OPERAND_WIDTH-1:0] In,
  input  logic [SHAMT_WIDTH-1:0]   ShAmt,
  input  logic [1:0]               Oper,
`ifdef SHR_PIPE_BYPASS_EN
  input  logic                     bypass,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OPERAND_WIDTH-1:0] result
);

  localparam int LAST = SHAMT_WIDTH - 1;

  logic [SHAMT_WIDTH-1:0]   stg_valid;
  logic [SHAMT_WIDTH-1:0]   stg_adv;
  logic [SHAMT_WIDTH-1:0]   nxt_adv;
  logic [SHAMT_WIDTH-1:0]   feed_valid;
  logic [OPERAND_WIDTH-1:0] stg_data  [SHAMT_WIDTH];
  logic [OPERAND_WIDTH-1:0] feed_data [SHAMT_WIDTH];
  logic [SHAMT_WIDTH-1:0]   stg_shamt [SHAMT_WIDTH];
  logic [SHAMT_WIDTH-1:0]   feed_shamt[SHAMT_WIDTH];
  logic [1:0]               stg_oper  [SHAMT_WIDTH];
  logic [1:0]               feed_oper [SHAMT_WIDTH];
  logic                     s0_valid;

`ifdef SHR_PIPE_BYPASS_EN
  logic                     upper_empty;
  logic                     byp_xfer;
  logic [SHAMT_WIDTH-1:0]   byp_amt;
  logic [OPERAND_WIDTH-1:0] byp_data;

  // Bypass only when nothing is ahead of the last stage, so ordering can never be violated.
  assign upper_empty = ~|stg_valid[LAST-1:0];
  assign in_ready    = bypass ? (upper_empty && stg_adv[LAST]) : stg_adv[0];
  assign byp_xfer    = in_valid && bypass && in_ready;
  assign s0_valid    = in_valid && !bypass;

  // The last stage still applies its own top-bit shift, so only the lower bits are done here.
  always_comb begin
    byp_amt          = ShAmt;
    byp_amt[LAST]    = 1'b0;
    case (Oper)
      SHR_ARITH:  byp_data = $signed(In) >>> byp_amt;
      SHR_ROTATE: byp_data = (In >> byp_amt) | (In << (OPERAND_WIDTH - int'(byp_amt)));
      default:    byp_data = In >> byp_amt;
    endcase
  end
`else
  assign in_ready = stg_adv[0];
  assign s0_valid = in_valid;
`endif

  for (genvar k = 0; k < SHAMT_WIDTH; k++) begin : g_stage
    if (k == 0) begin : g_feed
      assign feed_valid[k] = s0_valid;
      assign feed_data[k]  = In;
      assign feed_shamt[k] = ShAmt;
      assign feed_oper[k]  = Oper;
`ifdef SHR_PIPE_BYPASS_EN
    end else if (k == LAST) begin : g_feed
      assign feed_valid[k] = stg_valid[k-1] || byp_xfer;
      assign feed_data[k]  = byp_xfer ? byp_data : stg_data[k-1];
      assign feed_shamt[k] = byp_xfer ? ShAmt    : stg_shamt[k-1];
      assign feed_oper[k]  = byp_xfer ? Oper     : stg_oper[k-1];
`endif
    end else begin : g_feed
      assign feed_valid[k] = stg_valid[k-1];
      assign feed_data[k]  = stg_data[k-1];
      assign feed_shamt[k] = stg_shamt[k-1];
      assign feed_oper[k]  = stg_oper[k-1];
    end

    if (k == LAST) begin : g_next
      assign nxt_adv[k] = out_ready;
    end else begin : g_next
      assign nxt_adv[k] = stg_adv[k+1];
    end

    shift_right_stage #(
      .OPERAND_WIDTH (OPERAND_WIDTH),
      .SHAMT_WIDTH   (SHAMT_WIDTH),
      .STAGE_IDX     (k)
    ) u_stage (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (feed_valid[k]),
      .in_data      (feed_data[k]),
      .in_shamt     (feed_shamt[k]),
      .in_oper      (feed_oper[k]),
      .next_advance (nxt_adv[k]),
      .advance      (stg_adv[k]),
      .valid        (stg_valid[k]),
      .data         (stg_data[k]),
      .shamt        (stg_shamt[k]),
      .oper         (stg_oper[k])
    );
  end

  assign out_valid = stg_valid[LAST];
  assign result    = stg_data[LAST];

endmodule

// File: tb/tb_shift_right_pipe.sv
// Scoreboard bench for shift_right_pipe: stimulus pushes expected results, a monitor pops on handshake.
module tb_shift_right_pipe;

  localparam int W  = 16;
  localparam int SW = 4;
  localparam int PIPE_LAT = 4;

  typedef struct {
    logic [W-1:0] val;
    int           acc;
    int           lat;
    bit           exact;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [SW-1:0] shamt;
  logic [1:0]    oper;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
`ifdef SHR_PIPE_BYPASS_EN
  logic          bypass;
`endif

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle = 0;
  int   ready_mode = 1;

  shift_right_pipe #(.OPERAND_WIDTH(W), .SHAMT_WIDTH(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .In        (in_data),
    .ShAmt     (shamt),
    .Oper      (oper),
`ifdef SHR_PIPE_BYPASS_EN
    .bypass    (bypass),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Consumer: held low, held high, or random backpressure
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  function automatic logic [W-1:0] model(input logic [W-1:0] d, input int s, input logic [1:0] o);
    int unsigned u;
    int          sv;
    u = d;
    case (o)
      2'b01: begin
        sv = d[W-1] ? (int'(u) - 65536) : int'(u);
        return W'(sv >>> s);
      end
      2'b10:   return W'((u >> s) | (u << (W - s)));
      default: return W'(u >> s);
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the transfer edge
  task automatic applyStimulus(input logic [W-1:0] d, input logic [SW-1:0] s, input logic [1:0] o,
                               input logic b, input int lat, input bit exact, output int waited);
    exp_t e;
    bit   done;
    waited   = 0;
    done     = 0;
    in_valid = 1'b1;
    in_data  = d;
    shamt    = s;
    oper     = o;
`ifdef SHR_PIPE_BYPASS_EN
    bypass   = b;
`else
    if (b) $display("[TB] bypass requested without bypass build");
`endif
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        e.val   = model(d, int'(s), o);
        e.acc   = cycle;
        e.lat   = lat;
        e.exact = exact;
        sb.push_back(e);
        done = 1;
      end else begin
        waited++;
        if (waited > 200) begin
          checks++;
          errors++;
          $display("[TB] FAIL accept_timeout: in_ready stuck at %0b, required 1", in_ready);
          done = 1;
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
`ifdef SHR_PIPE_BYPASS_EN
    bypass   = 1'b0;
`endif
  endtask

  task automatic waitDrain();
    int n = 0;
    while (sb.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    checkOutput("drain_empty", sb.size(), 0);
  endtask

  // Monitor: hold rule and in-order scoreboard comparison on every output handshake
  initial begin
    exp_t         e;
    bit           hold_prev = 0;
    logic [W-1:0] prev_result = '0;
    int           lat_meas;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_prev = 0;
        continue;
      end
      if (hold_prev) begin
        checkOutput("hold_valid", out_valid, 1);
        checkOutput("hold_result", result, prev_result);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_output: got %0h, required no output", result);
        end else begin
          e = sb.pop_front();
          lat_meas = cycle - e.acc;
          checkOutput("result", result, e.val);
          if (e.exact) checkOutput("latency", lat_meas, e.lat);
          else         checkOutput("min_latency", (lat_meas >= e.lat), 1);
        end
      end
      hold_prev   = out_valid && !out_ready;
      prev_result = result;
    end
  end

  initial begin
    int w;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    shamt    = '0;
    oper     = 2'b00;
`ifdef SHR_PIPE_BYPASS_EN
    bypass   = 1'b0;
`endif
    #1;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_result", result, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("release_in_ready", in_ready, 1);
    checkOutput("release_out_valid", out_valid, 0);
    @(posedge clk);
    #1;

    // Directed operand patterns with no backpressure: exact latency
    applyStimulus(16'h8001, 4'd4, 2'b00, 1'b0, PIPE_LAT, 1, w);
    applyStimulus(16'h8001, 4'd4, 2'b01, 1'b0, PIPE_LAT, 1, w);
    applyStimulus(16'h8001, 4'd4, 2'b10, 1'b0, PIPE_LAT, 1, w);
    applyStimulus(16'h8001, 4'd4, 2'b11, 1'b0, PIPE_LAT, 1, w);
    for (int o = 0; o < 4; o++)
      applyStimulus(16'hA5A5, 4'd0, 2'(o), 1'b0, PIPE_LAT, 1, w);
    applyStimulus(16'h8000, 4'd15, 2'b01, 1'b0, PIPE_LAT, 1, w);
    applyStimulus(16'hFFFF, 4'd15, 2'b00, 1'b0, PIPE_LAT, 1, w);
    applyStimulus(16'h0001, 4'd15, 2'b10, 1'b0, PIPE_LAT, 1, w);
    waitDrain();

    // Fill the pipe with the consumer stalled, then release it together with a new input
    ready_mode = 0;
    for (int i = 0; i < 4; i++)
      applyStimulus(16'h1111 * (i + 1), 4'(i + 1), 2'(i), 1'b0, PIPE_LAT, 0, w);
    @(negedge clk);
    checkOutput("in_ready_full", in_ready, 0);
    repeat (3) @(posedge clk);
    #1;
    ready_mode = 1;
    applyStimulus(16'hC3C3, 4'd5, 2'b01, 1'b0, PIPE_LAT, 0, w);
    checkOutput("simul_accept_wait", w, 0);
    applyStimulus(16'h3C3C, 4'd9, 2'b10, 1'b0, PIPE_LAT, 0, w);
    waitDrain();

`ifdef SHR_PIPE_BYPASS_EN
    applyStimulus(16'h00F0, 4'd4, 2'b00, 1'b1, 1, 1, w);
    waitDrain();
    applyStimulus(16'h1234, 4'd1, 2'b00, 1'b0, PIPE_LAT, 1, w);
    in_valid = 1'b1;
    bypass   = 1'b1;
    in_data  = 16'h8F00;
    shamt    = 4'd12;
    oper     = 2'b01;
    @(negedge clk);
    checkOutput("bypass_blocked", in_ready, 0);
    @(posedge clk);
    #1;
    applyStimulus(16'h8F00, 4'd12, 2'b01, 1'b1, 1, 1, w);
    checkOutput("bypass_waited", (w > 0), 1);
    waitDrain();
`endif

    // Randomized traffic under random backpressure
    ready_mode = 2;
    for (int i = 0; i < 150; i++) begin
      logic b;
      b = 1'b0;
`ifdef SHR_PIPE_BYPASS_EN
      b = ($urandom_range(0, 5) == 0);
`endif
      applyStimulus(W'($urandom), SW'($urandom), 2'($urandom), b, b ? 1 : PIPE_LAT, 0, w);
    end
    ready_mode = 1;
    waitDrain();

    // Asynchronous reset with three transactions in flight
    applyStimulus(16'hDEAD, 4'd1, 2'b00, 1'b0, PIPE_LAT, 1, w);
    applyStimulus(16'hBEEF, 4'd2, 2'b01, 1'b0, PIPE_LAT, 1, w);
    applyStimulus(16'hCAFE, 4'd3, 2'b10, 1'b0, PIPE_LAT, 1, w);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    checkOutput("async_rst_out_valid", out_valid, 0);
    checkOutput("async_rst_result", result, 0);
    checkOutput("async_rst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_in_ready", in_ready, 1);
    checkOutput("post_rst_out_valid", out_valid, 0);
    repeat (8) @(posedge clk);
    #1;
    checkOutput("no_stale_output", out_valid, 0);
    applyStimulus(16'h1234, 4'd3, 2'b01, 1'b0, PIPE_LAT, 1, w);
    waitDrain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_right_pipe.md
Name: shift_right_pipe

Overview:
- Pipelined right shifter/rotator. Counterpart to the team's combinational left barrel shifter.
- Serves the ALU's SRL/SRA/ROR class of instructions and any multi-cycle datapath user that needs registered timing.
- Uses one pipeline stage per shift-amount bit, with valid/ready handshakes on both ends.
- Accepts a new operand every cycle when downstream is ready.

Parameters:
- OPERAND_WIDTH, 16, data width in bits; must be greater than 2^(SHAMT_WIDTH-1).
- SHAMT_WIDTH, 4, shift-amount width; also the number of pipeline stages.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  In/ShAmt/Oper are valid this cycle.
- in_ready  output  1  stage 0 can accept; a transfer occurs when in_valid and in_ready are both high.
- In  input  OPERAND_WIDTH  operand.
- ShAmt  input  SHAMT_WIDTH  shift amount, 0..2^SHAMT_WIDTH-1.
- Oper  input  2  00 logical right, 01 arithmetic right, 10 rotate right, 11 reserved (treated as logical).
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts result this cycle.
- result  output  OPERAND_WIDTH  shifted value, driven from the last stage register.

Behaviour:
- Stages: stage k (k = 0..SHAMT_WIDTH-1) registers a valid bit, data, the remaining ShAmt bits and Oper.
  - Stage k shifts right by 2^k when ShAmt[k]=1, otherwise passes data through.
  - Fill bits for the vacated top positions:
    - logical: 0.
    - arithmetic: the operand MSB; the original sign is preserved through every stage.
    - rotate: the low bits shifted out wrap into the top.
- Latency: exactly SHAMT_WIDTH cycles from accepted input to out_valid, i.e. 4 by default, with no stalls. Throughput is 1 per cycle.
- Flow control:
  - Stage k advances when its own valid is low or stage k+1 advances.
  - The last stage advances when out_ready is high or out_valid is low.
  - in_ready equals stage 0's advance condition, so it is combinational from out_ready through the valid chain.
  - A stalled stage holds its data and valid unchanged.
- Hold rule: result and out_valid stay stable while out_valid=1 and out_ready=0. No transaction is dropped or duplicated, and order is preserved.
- Bubbles: a stage receiving no valid input clears its valid. Data in invalid stages is don't-care but must not produce X on result once out_valid=1.
- Boundary cases:
  - ShAmt=0 returns In unchanged for every Oper.
  - ShAmt=2^SHAMT_WIDTH-1 with a logical shift on a 16-bit operand leaves only bit 15 of In, moved to bit 0.
- Simultaneous events: the pipeline full while out_ready rises in the same cycle as in_valid means the input is accepted and every stage advances in that cycle.
- Reset:
  - All valid bits, data and result clear to 0 immediately on rst assertion, including mid-operation. In-flight transactions are discarded.
  - in_ready is 1 and out_valid is 0 during reset and on the first cycle after release.
- Oper=11 produces exactly the logical result; no error is flagged.

Optional Feature:
- Macro SHR_PIPE_BYPASS_EN.
- When defined:
  - an extra input `bypass` (1 bit) is present.
  - A transaction accepted with bypass=1 skips all stages. It goes straight into the last stage register with a 1-cycle latency.
  - Bypass is legal only when stages 0..SHAMT_WIDTH-2 are all empty; in_ready is deasserted for bypass requests otherwise, to preserve ordering.
- When undefined: the port is absent and latency is always SHAMT_WIDTH.

Decomposition:
- Shared package shift_pkg holds:
  - the Oper encodings SHR_LOGICAL=2'b00, SHR_ARITH=2'b01, SHR_ROTATE=2'b10.
  - default OPERAND_WIDTH/SHAMT_WIDTH constants.
  - the localparam stage count.
- One natural sub-module: shift_right_stage.
  - Parameterised by STAGE_IDX; contains the valid/data/ctl registers, the stall logic and the conditional 2^STAGE_IDX shift.
  - Instantiated SHAMT_WIDTH times via generate.

Test Plan:
- In=16'h8001, ShAmt=4, Oper=00, out_ready=1 -> result=16'h0800, out_valid exactly 4 cycles after acceptance.
- Same operand, Oper=01 -> 16'hF800; Oper=10 -> 16'h1800; Oper=11 -> 16'h0800.
- ShAmt=0, In=16'hA5A5, all Oper values -> 16'hA5A5; ShAmt=15, Oper=01, In=16'h8000 -> 16'hFFFF.
- Stream 6 back-to-back inputs with out_ready held low for cycles 5-7:
  - in_ready drops once all 4 stages are full.
  - result stays stable while stalled.
  - all 6 outputs arrive in order with no loss or duplication.
- rst asserted asynchronously with 3 transactions in flight -> out_valid=0 and result=0 immediately; no stale output after release; in_ready=1.
- With SHR_PIPE_BYPASS_EN defined:
  - bypass=1, In=16'h00F0, ShAmt=4, Oper=00 on an empty pipe -> 16'h000F after 1 cycle.
  - a bypass request with a non-empty pipe -> in_ready=0 until the stages drain.
